// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan controller.
package seg_pkg;
    localparam int CODE_W = 5;

    typedef logic [CODE_W-1:0] code_t;

    // Bit 4 set selects the special glyph set; 5'h10 is the blank glyph.
    localparam code_t BLANK_CODE   = 5'h10;
    localparam code_t GLYPH_DASH   = 5'h11;
    localparam code_t GLYPH_UNDER  = 5'h12;
    localparam code_t GLYPH_DEGREE = 5'h13;
    localparam code_t GLYPH_E      = 5'h14;
    localparam code_t GLYPH_R      = 5'h15;
    localparam code_t GLYPH_P      = 5'h16;
endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer: cnt within a slot, idx of the digit, BLANK/DRIVE phase and frame wrap.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 2,
    localparam int CNT_W       = $clog2(TICK_DIV),
    localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             drive,
    output logic             frame_wrap
);
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             idx_last;

    // Explicit terminal compares so non-power-of-two sizes wrap correctly.
    assign cnt_last   = (cnt == CNT_W'(TICK_DIV - 1));
    assign idx_last   = (idx == IDX_W'(NUM_DIGITS - 1));
    assign drive      = (32'(cnt) >= 32'(BLANK_CYCLES));
    assign frame_wrap = en & cnt_last & idx_last;

    // Slot counter and digit index; disabling parks both at slot 0 so a restart begins blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
            idx <= idx_last ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scan controller with double-buffered image and leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         load,
    input  logic [CODE_W*NUM_DIGITS-1:0] load_data,
    input  logic                         lz_en,
    output logic                         load_ready,
    output logic [CODE_W-1:0]            digit_code,
    output logic [NUM_DIGITS-1:0]        digit_sel,
    output logic                         frame_done
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [NUM_DIGITS-1:0][CODE_W-1:0] active_img;
    logic [NUM_DIGITS-1:0][CODE_W-1:0] shadow_img;
    logic [NUM_DIGITS-1:0][CODE_W-1:0] eff_code;
    logic [NUM_DIGITS:1]               zero_above;
    logic [IDX_W-1:0]                  idx;
    logic                              drive;
    logic                              frame_wrap;
    logic                              accept;
    logic                              xfer;
    logic [NUM_DIGITS-1:0]             sel_onehot;

    seg_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .TICK_DIV    (TICK_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .idx       (idx),
        .drive     (drive),
        .frame_wrap(frame_wrap)
    );

    // Shadow is full whenever load_ready is low; transfer decisions use pre-edge state,
    // so a load landing on the boundary edge waits for the next boundary.
    assign accept = load & load_ready;
    assign xfer   = ~load_ready & (frame_wrap | ~en);

    // Leading-zero chain runs from the top digit down; digit 0 always shows its code.
    assign zero_above[NUM_DIGITS] = 1'b1;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
        if (i == 0) begin : g_d0
            assign eff_code[0] = active_img[0];
        end else begin : g_dn
            assign zero_above[i] = zero_above[i+1] & (active_img[i] == '0);
            assign eff_code[i]   = (lz_en && zero_above[i]) ? BLANK_CODE : active_img[i];
        end
    end

    assign sel_onehot = NUM_DIGITS'(1) << idx;

    // Double buffer: load into shadow, promote to active at frame wrap or while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_img <= {NUM_DIGITS{BLANK_CODE}};
            shadow_img <= '0;
            load_ready <= 1'b1;
        end else begin
            if (accept) shadow_img <= load_data;
            if (xfer)   active_img <= shadow_img;
            if (accept)    load_ready <= 1'b0;
            else if (xfer) load_ready <= 1'b1;
        end
    end

    // Registered pin drive, one cycle behind the slot timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sel  <= '0;
            digit_code <= BLANK_CODE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            if (en && drive) begin
                digit_sel  <= sel_onehot;
                digit_code <= eff_code[idx];
            end else begin
                digit_sel  <= '0;
                digit_code <= BLANK_CODE;
            end
        end
    end
endmodule
